// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, hazard FSM
// encodings and the shadow-pipe entry used by hazard control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] HZ_RUN   = 2'd0;
  localparam logic [1:0] HZ_STALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sh_ent_t;

  typedef struct packed {
    logic       rs_rd_en;
    logic       rt_rd_en;
    logic       wr_en;
    logic [4:0] wr_rd;
  } dec_t;

  function automatic logic sh_hit(
    input sh_ent_t [2:0] sh,
    input logic    [4:0] r
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (sh[k].vld && sh[k].rd == r) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// HAZ_PERF_CNT_EN adds the stall/flush performance counters.
interface pipeline_hazard_ctrl_if
`ifdef HAZ_PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;

  logic [31:0] id_ir;
  logic        id_valid;
  logic        dx_jump;
  logic        br_taken;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_flush;
  logic [1:0]  hz_state;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    output id_ir, id_valid,
    output dx_jump, br_taken,
    input  pc_we, ifid_we,
    input  ifid_flush, idex_bubble,
    input  exmem_flush, hz_state
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_ir, id_valid,
    input  dx_jump, br_taken,
    output pc_we, ifid_we,
    output ifid_flush, idex_bubble,
    output exmem_flush, hz_state
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_decode.sv
// Register read/write decode of the instruction in IF/ID.
// $0 is filtered here: it never hazards and is never recorded.
module hazard_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_lo;

  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign unused_lo = ^ir[10:0];

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dec.rs_rd_en = 1'b1;
        dec.rt_rd_en = 1'b1;
        dec.wr_en    = 1'b1;
        dec.wr_rd    = rd;
      end
      (op == OP_LW): begin
        dec.rs_rd_en = 1'b1;
        dec.wr_en    = 1'b1;
        dec.wr_rd    = rt;
      end
      (op == OP_SW),
      (op == OP_BEQ),
      (op == OP_BNE): begin
        dec.rs_rd_en = 1'b1;
        dec.rt_rd_en = 1'b1;
      end
      default: ;
    endcase
    dec.rs_rd_en = dec.rs_rd_en && (rs != 5'd0);
    dec.rt_rd_en = dec.rt_rd_en && (rt != 5'd0);
    dec.wr_en    = dec.wr_en && (dec.wr_rd != 5'd0);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW stall / branch-jump flush sequencer, no-forwarding MIPS.
// HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int FLUSH_LEN = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  dec_t          dec;
  sh_ent_t [2:0] sh_q, sh_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic          hazard;
  logic          pc_we, ifid_we;
  logic          ifid_flush, idex_bubble;
  logic          exmem_flush;

  hazard_decode u_dec (
    .ir  (bus.id_ir),
    .dec (dec)
  );

  assign hazard = bus.id_valid &&
    ((dec.rs_rd_en && sh_hit(sh_q, bus.id_ir[25:21])) ||
     (dec.rt_rd_en && sh_hit(sh_q, bus.id_ir[20:16])));

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    sh_d[2]     = sh_q[1];
    sh_d[1]     = sh_q[0];
    sh_d[0]     = '0;
    if (bus.br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      sh_d[1]     = '0;
      state_d     = HZ_FLUSH;
      fcnt_d      = FLUSH_LEN[1:0];
    end else if (bus.dx_jump) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = HZ_FLUSH;
      fcnt_d      = FLUSH_LEN[1:0];
    end else if (state_q == HZ_FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (fcnt_q <= 2'd1) begin
        fcnt_d  = 2'd0;
        state_d = HZ_RUN;
      end else begin
        fcnt_d  = fcnt_q - 2'd1;
      end
    end else if (hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = HZ_STALL;
    end else begin
      state_d    = HZ_RUN;
      sh_d[0].vld = bus.id_valid && dec.wr_en;
      sh_d[0].rd  = dec.wr_rd;
    end
    // Reset overrides the outputs asynchronously.
    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      state_q <= HZ_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      sh_q    <= sh_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_flush = exmem_flush;
  assign bus.hz_state    = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_ev, flush_ev;

  assign flush_ev = bus.br_taken || bus.dx_jump;
  assign stall_ev = !flush_ev &&
    (state_q != HZ_FLUSH) && hazard;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ev && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// HAZ_PERF_CNT_EN also checks the performance counters.
module tb_pipeline_hazard_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  pipeline_hazard_ctrl #(.FLUSH_LEN(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus2.id_ir    = bus.id_ir;
  assign bus2.id_valid = bus.id_valid;
  assign bus2.dx_jump  = bus.dx_jump;
  assign bus2.br_taken = bus.br_taken;

  pipeline_hazard_ctrl #(.FLUSH_LEN(1), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );
`else
  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.FLUSH_LEN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  function automatic logic [31:0] rty(
    input logic [4:0] rs, rt, rd
  );
    return {OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] ity(
    input logic [5:0] op,
    input logic [4:0] rs, rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  task automatic step(
    input logic [31:0] ir,
    input logic v, j, b
  );
    @(posedge clk);
    #1;
    bus.id_ir    = ir;
    bus.id_valid = v;
    bus.dx_jump  = j;
    bus.br_taken = b;
    #2;
  endtask

  // exp = {pc_we, ifid_we, ifid_flush,
  //        idex_bubble, exmem_flush, hz_state}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {bus.pc_we, bus.ifid_we, bus.ifid_flush,
           bus.idex_bubble, bus.exmem_flush, bus.hz_state};
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chkv(
    input string tag,
    input logic [15:0] got, exp
  );
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] add3, add4, lw5, sw5, jmp, beq;

  initial begin
    add3 = rty(5'd1, 5'd2, 5'd3);
    add4 = rty(5'd3, 5'd1, 5'd4);
    lw5  = ity(OP_LW, 5'd0, 5'd5, 16'd0);
    sw5  = ity(OP_SW, 5'd0, 5'd5, 16'd4);
    jmp  = {OP_J, 26'h10};
    beq  = ity(OP_BEQ, 5'd1, 5'd2, 16'd8);
    bus.id_ir    = '0;
    bus.id_valid = 1'b0;
    bus.dx_jump  = 1'b0;
    bus.br_taken = 1'b0;

    #3 chk("reset", {5'b00111, HZ_RUN});
    @(negedge clk) rst = 1'b1;

    // RAW on $3: three stall cycles then issue
    step(add3, 1'b1, 1'b0, 1'b0);
    chk("s1_issue", {5'b11000, HZ_RUN});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s1_stall0", {5'b00010, HZ_RUN});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s1_stall1", {5'b00010, HZ_STALL});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s1_stall2", {5'b00010, HZ_STALL});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s1_go", {5'b11000, HZ_STALL});
    step('0, 1'b0, 1'b0, 1'b0);
    chk("s1_run", {5'b11000, HZ_RUN});
    drain();

    // taken branch squashes the add $3 sitting in ID
    step(add3, 1'b1, 1'b0, 1'b1);
    chk("s3_br", {5'b11111, HZ_RUN});
    step(beq, 1'b1, 1'b0, 1'b0);
    chk("s3_flush", {5'b11110, HZ_FLUSH});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s3_nostall", {5'b11000, HZ_RUN});
    drain();
`ifdef HAZ_PERF_CNT_EN
    chkv("s6_stall_cnt", bus.stall_cnt, 16'd3);
    chkv("s6_flush_cnt", bus.flush_cnt, 16'd1);
`endif

    // load-use, then $0 sources/destinations
    step(lw5, 1'b1, 1'b0, 1'b0);
    chk("s2_lw", {5'b11000, HZ_RUN});
    step(sw5, 1'b1, 1'b0, 1'b0);
    chk("s2_stall0", {5'b00010, HZ_RUN});
    step(sw5, 1'b1, 1'b0, 1'b0);
    chk("s2_stall1", {5'b00010, HZ_STALL});
    step(sw5, 1'b1, 1'b0, 1'b0);
    chk("s2_stall2", {5'b00010, HZ_STALL});
    step(sw5, 1'b1, 1'b0, 1'b0);
    chk("s2_sw_go", {5'b11000, HZ_STALL});
    step(rty(5'd1, 5'd2, 5'd0), 1'b1, 1'b0, 1'b0);
    chk("s2_wr_r0", {5'b11000, HZ_RUN});
    step(rty(5'd0, 5'd0, 5'd7), 1'b1, 1'b0, 1'b0);
    chk("s2_rd_r0", {5'b11000, HZ_RUN});
    drain();
`ifdef HAZ_PERF_CNT_EN
    chkv("s6_stall6", bus.stall_cnt, 16'd6);
    chkv("s6_sat", {14'd0, bus2.stall_cnt}, 16'd3);
`endif

    // jump beats a pending RAW stall
    step(add3, 1'b1, 1'b0, 1'b0);
    chk("s4_add3", {5'b11000, HZ_RUN});
    step(jmp, 1'b1, 1'b0, 1'b0);
    chk("s4_j", {5'b11000, HZ_RUN});
    step(add4, 1'b1, 1'b1, 1'b0);
    chk("s4_jwin", {5'b11110, HZ_RUN});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s4_flush", {5'b11110, HZ_FLUSH});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s4_nostall", {5'b11000, HZ_RUN});
    drain();

    // writer in ID during jump must not be recorded
    step(rty(5'd1, 5'd2, 5'd6), 1'b1, 1'b1, 1'b0);
    chk("s4b_j", {5'b11110, HZ_RUN});
    step('0, 1'b0, 1'b0, 1'b0);
    chk("s4b_flush", {5'b11110, HZ_FLUSH});
    step(rty(5'd6, 5'd6, 5'd7), 1'b1, 1'b0, 1'b0);
    chk("s4b_nostall", {5'b11000, HZ_RUN});
    drain();

    // async reset in the middle of a stall
    step(add3, 1'b1, 1'b0, 1'b0);
    chk("s5_add3", {5'b11000, HZ_RUN});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s5_stall0", {5'b00010, HZ_RUN});
    step(add4, 1'b1, 1'b0, 1'b0);
    chk("s5_stall1", {5'b00010, HZ_STALL});
    #1 rst = 1'b0;
    #1 chk("s5_rst", {5'b00111, HZ_RUN});
    #2 rst = 1'b1;
    #1 chk("s5_fresh", {5'b11000, HZ_RUN});
    step(rty(5'd3, 5'd3, 5'd9), 1'b1, 1'b0, 1'b0);
    chk("s5_issue", {5'b11000, HZ_RUN});
`ifdef HAZ_PERF_CNT_EN
    chkv("s5_cnt_clr", bus.flush_cnt, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
